sync_ram_bytelane: RTL and testbench

Parametrised single-clock RAM with independent read and write ports. Generalises the team's 16x8 single-address register-file memory to configurable width and depth, adding:
- per-byte-lane write enables
- selectable read latency
- selectable read-during-write policy
- a hardware clear engine that initialises the array after reset or on request

Used as the generic storage primitive behind peripheral register banks and small lookup tables.

---
 rtl/sync_ram_bytelane.sv | 132 +++++++++++++
 tb/tb_sync_ram_bytelane.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_bytelane.sv
// Single-clock RAM with separate read/write ports, byte-lane writes, 1- or 2-cycle reads and a clear engine.
// Latency: READ_LATENCY cycles from an accepted read to r_valid; no backpressure, requests ignored while busy.
module sync_ram_bytelane #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int DEPTH          = 16,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 r_en,
    input  logic [ADDR_WIDTH-1:0]                r_adr,
    output logic [DATA_WIDTH-1:0]                r_dat,
    output logic                                 r_valid,
    input  logic                                 w_en,
    input  logic [ADDR_WIDTH-1:0]                w_adr,
    input  logic [DATA_WIDTH-1:0]                w_dat,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     w_sel,
    input  logic                                 clear,
    output logic                                 busy
);

    localparam int NLANES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic                    r_s1_vld;
    logic [DATA_WIDTH-1:0]   r_s1_dat;

    logic                    w_wr_ok;
    logic                    w_rd_acc;
    logic                    w_rd_in_range;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    assign busy          = (r_state == S_CLEAR);
    assign w_wr_ok       = ~busy & w_en & ({1'b0, w_adr} < DEPTH_W);
    assign w_rd_acc      = ~busy & r_en;
    assign w_rd_in_range = ({1'b0, r_adr} < DEPTH_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_state <= S_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_ptr == LAST_PTR) begin
                        r_state <= S_IDLE;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The clear engine owns the write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (busy && !rst) begin
            r_mem[r_ptr] <= CLEAR_VALUE;
        end else if (w_wr_ok) begin
            for (int i = 0; i < NLANES; i++) begin
                if (w_sel[i]) begin
                    r_mem[w_adr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_dat[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[r_adr];
            if ((RDW_MODE != 0) && w_wr_ok && (w_adr == r_adr)) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (w_sel[i]) begin
                        w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = w_dat[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
        end else begin
            r_s1_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_dat <= w_rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_dat   <= '0;
                end else begin
                    r_valid <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_dat <= r_s1_dat;
                    end
                end
            end
        end else begin : g_lat1
            assign r_valid = r_s1_vld;
            assign r_dat   = r_s1_dat;
        end
    endgenerate

endmodule

// File: tb/tb_sync_ram_bytelane.sv
// Two RAM configurations: A = 32-bit/12-deep/latency 1/old-data RDW, B = 8-bit/16-deep/latency 2/new-data RDW.
module tb_sync_ram_bytelane;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        re;
        logic [3:0]  ra;
        logic [31:0] ex;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en_a, w_en_a, clear_a, r_valid_a, busy_a;
    logic [3:0]  r_adr_a, w_adr_a, w_sel_a;
    logic [31:0] w_dat_a, r_dat_a;
    logic        r_en_b, w_en_b, clear_b, r_valid_b, busy_b;
    logic [3:0]  r_adr_b, w_adr_b;
    logic [0:0]  w_sel_b;
    logic [7:0]  w_dat_b, r_dat_b;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   vld_a = 0;
    int   vld_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    vec_t tv_a[13];
    vec_t tv_b[13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sync_ram_bytelane #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hA5A5A5A5)
    ) dut_a (
        .clk(clk), .rst(rst), .r_en(r_en_a), .r_adr(r_adr_a), .r_dat(r_dat_a), .r_valid(r_valid_a),
        .w_en(w_en_a), .w_adr(w_adr_a), .w_dat(w_dat_a), .w_sel(w_sel_a), .clear(clear_a), .busy(busy_a)
    );

    sync_ram_bytelane #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)
    ) dut_b (
        .clk(clk), .rst(rst), .r_en(r_en_b), .r_adr(r_adr_b), .r_dat(r_dat_b), .r_valid(r_valid_b),
        .w_en(w_en_b), .w_adr(w_adr_b), .w_dat(w_dat_b), .w_sel(w_sel_b), .clear(clear_b), .busy(busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every completing read must match the oldest outstanding expectation and its due cycle.
    always @(negedge clk) begin
        if (r_valid_a === 1'b1) begin
            vld_a++;
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_vld_a: got r_valid=1 data %h want no completion", r_dat_a);
            end else begin
                ea = q_a.pop_front();
                chk("rd_a_data", r_dat_a, ea.d);
                chk("rd_a_cycle", cyc, ea.due);
            end
        end
        if (r_valid_b === 1'b1) begin
            vld_b++;
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_vld_b: got r_valid=1 data %h want no completion", r_dat_b);
            end else begin
                eb = q_b.pop_front();
                chk("rd_b_data", {24'h0, r_dat_b}, eb.d);
                chk("rd_b_cycle", cyc, eb.due);
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic [3:0] ws, input logic re, input logic [3:0] ra,
                                input logic [31:0] ex);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ws = ws; v.re = re; v.ra = ra; v.ex = ex;
        return v;
    endfunction

    task automatic drive(input int which, input vec_t v);
        if (which == 0) begin
            w_en_a = v.we; w_adr_a = v.wa; w_dat_a = v.wd; w_sel_a = v.ws;
            r_en_a = v.re; r_adr_a = v.ra;
            if (v.re) q_a.push_back('{d: v.ex, due: cyc + 1});
        end else begin
            w_en_b = v.we; w_adr_b = v.wa; w_dat_b = v.wd[7:0]; w_sel_b = v.ws[0];
            r_en_b = v.re; r_adr_b = v.ra;
            if (v.re) q_b.push_back('{d: v.ex, due: cyc + 2});
        end
        @(negedge clk);
        if (which == 0) begin w_en_a = 0; r_en_a = 0; end
        else begin w_en_b = 0; r_en_b = 0; end
    endtask

    // Counts busy cycles starting from the current negedge; drops that port's r_en once idle.
    task automatic count_busy(input int which, output int n);
        n = 0;
        while (((which == 0) ? busy_a : busy_b) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (which == 0) r_en_a = 0; else r_en_b = 0;
    endtask

    task automatic read_all(input int which);
        int depth;
        depth = (which == 0) ? 12 : 16;
        for (int i = 0; i < depth; i++) begin
            drive(which, mk(0, 4'h0, 32'h0, 4'h0, 1, 4'(i), (which == 0) ? 32'hA5A5A5A5 : 32'h000000A5));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, v0a, v0b;

        tv_a[0]  = mk(1, 4'd3,  32'h11223344, 4'hF,    0, 4'd0,  32'h0);
        tv_a[1]  = mk(1, 4'd3,  32'hAABBCCDD, 4'b0101, 1, 4'd3,  32'h11223344);
        tv_a[2]  = mk(0, 4'd0,  32'h0,        4'h0,    1, 4'd3,  32'h11BB33DD);
        tv_a[3]  = mk(1, 4'd13, 32'hFFFFFFFF, 4'hF,    1, 4'd13, 32'h0);
        tv_a[4]  = mk(0, 4'd0,  32'h0,        4'h0,    1, 4'd11, 32'hA5A5A5A5);
        tv_a[5]  = mk(0, 4'd0,  32'h0,        4'h0,    1, 4'd13, 32'h0);
        tv_a[6]  = mk(1, 4'd5,  32'h00000010, 4'hF,    0, 4'd0,  32'h0);
        tv_a[7]  = mk(1, 4'd5,  32'h00000077, 4'hF,    1, 4'd5,  32'h00000010);
        tv_a[8]  = mk(0, 4'd0,  32'h0,        4'h0,    1, 4'd5,  32'h00000077);
        tv_a[9]  = mk(1, 4'd7,  32'hDEADBEEF, 4'h0,    1, 4'd7,  32'hA5A5A5A5);
        tv_a[10] = mk(0, 4'd0,  32'h0,        4'h0,    1, 4'd7,  32'hA5A5A5A5);
        tv_a[11] = mk(1, 4'd0,  32'h12345678, 4'b1000, 1, 4'd2,  32'hA5A5A5A5);
        tv_a[12] = mk(0, 4'd0,  32'h0,        4'h0,    1, 4'd0,  32'h12A5A5A5);

        tv_b[0]  = mk(1, 4'd5, 32'h10, 4'h1, 0, 4'd0, 32'h0);
        tv_b[1]  = mk(1, 4'd5, 32'h77, 4'h1, 1, 4'd5, 32'h77);
        tv_b[2]  = mk(0, 4'd0, 32'h0,  4'h0, 1, 4'd5, 32'h77);
        tv_b[3]  = mk(1, 4'd0, 32'h01, 4'h1, 0, 4'd0, 32'h0);
        tv_b[4]  = mk(1, 4'd1, 32'h02, 4'h1, 0, 4'd0, 32'h0);
        tv_b[5]  = mk(1, 4'd2, 32'h03, 4'h1, 0, 4'd0, 32'h0);
        tv_b[6]  = mk(1, 4'd3, 32'h04, 4'h1, 0, 4'd0, 32'h0);
        tv_b[7]  = mk(0, 4'd0, 32'h0,  4'h0, 1, 4'd0, 32'h01);
        tv_b[8]  = mk(0, 4'd0, 32'h0,  4'h0, 1, 4'd1, 32'h02);
        tv_b[9]  = mk(0, 4'd0, 32'h0,  4'h0, 1, 4'd2, 32'h03);
        tv_b[10] = mk(0, 4'd0, 32'h0,  4'h0, 1, 4'd3, 32'h04);
        tv_b[11] = mk(1, 4'd9, 32'hFF, 4'h0, 1, 4'd9, 32'hA5);
        tv_b[12] = mk(0, 4'd0, 32'h0,  4'h0, 1, 4'd9, 32'hA5);

        rst = 0;
        r_en_a = 0; r_adr_a = 0; w_en_a = 0; w_adr_a = 0; w_dat_a = 0; w_sel_a = 0; clear_a = 0;
        r_en_b = 0; r_adr_b = 0; w_en_b = 0; w_adr_b = 0; w_dat_b = 0; w_sel_b = 0; clear_b = 0;
        #1 rst = 1;
        @(negedge clk); @(negedge clk);
        chk("rst_busy_a", {31'h0, busy_a}, 32'h1);
        chk("rst_busy_b", {31'h0, busy_b}, 32'h1);
        chk("rst_vld_a", {31'h0, r_valid_a}, 32'h0);
        chk("rst_vld_b", {31'h0, r_valid_b}, 32'h0);
        chk("rst_dat_a", r_dat_a, 32'h0);
        chk("rst_dat_b", {24'h0, r_dat_b}, 32'h0);

        // Reads held high across the power-up clear must all be dropped.
        r_en_a = 1; r_adr_a = 4'd2; r_en_b = 1; r_adr_b = 4'd3;
        v0a = vld_a; v0b = vld_b;
        rst = 0;
        fork
            count_busy(0, na);
            count_busy(1, nb);
        join
        chk("clr_len_a", na, 12);
        chk("clr_len_b", nb, 16);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("busy_rd_a", vld_a - v0a, 0);
        chk("busy_rd_b", vld_b - v0b, 0);

        read_all(0);
        read_all(1);
        for (int i = 0; i < 13; i++) drive(0, tv_a[i]);
        for (int i = 0; i < 13; i++) drive(1, tv_b[i]);
        repeat (4) @(negedge clk);

        // Requested clear with a second, ignored clear pulse part-way through.
        clear_b = 1;
        @(negedge clk);
        clear_b = 0;
        nb = 0;
        while (busy_b && nb < 100) begin
            nb++;
            clear_b = (nb == 5);
            @(negedge clk);
        end
        clear_b = 0;
        chk("req_clr_len_b", nb, 16);

        // Reset after 7 clear cycles: the clear must restart from address 0.
        clear_b = 1;
        @(negedge clk);
        clear_b = 0;
        nb = 0;
        while (busy_b && nb < 7) begin
            nb++;
            @(negedge clk);
        end
        rst = 1;
        #1 chk("busy_in_rst_b", {31'h0, busy_b}, 32'h1);
        @(negedge clk); @(negedge clk);
        rst = 0;
        count_busy(1, nb);
        chk("rst_mid_clr_len_b", nb, 16);
        count_busy(0, na);
        chk("a_idle_after_rst", {31'h0, busy_a}, 32'h0);
        read_all(1);
        read_all(0);

        repeat (5) @(negedge clk);
        chk("pending_a", q_a.size(), 0);
        chk("pending_b", q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
